// File: rtl/pic_bus_arbiter.sv
// Two-requester bus arbiter in front of the pic_wrapper bus port.
// Requester 0 is the CPU bus, requester 1 the loader/debug port. A grant is
// taken from IDLE with one cycle of arbitration latency. Ties go to the
// requester that was not granted last. A wait counter aborts a grant whose
// slave never answers, returning all-ones data and setting a sticky flag.
//
// Handshake: a requester raises wen and/or ren and holds them, together with
// address and write data, until it sees its own ready for exactly one cycle.
// The slave answers with a single-cycle s_ready while its strobe is high.
// After every completion (ready, abort or dropped request) the arbiter
// spends one cycle in IDLE before the next grant.
module pic_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] m0_address,
    input  logic [31:0] m0_data_in,
    input  logic        m0_wen,
    input  logic        m0_ren,
    output logic [31:0] m0_data_out,
    output logic        m0_ready,
    input  logic [15:0] m1_address,
    input  logic [31:0] m1_data_in,
    input  logic        m1_wen,
    input  logic        m1_ren,
    output logic [31:0] m1_data_out,
    output logic        m1_ready,
    output logic [15:0] s_address,
    output logic [31:0] s_data_in,
    output logic        s_wen,
    output logic        s_ren,
    input  logic [31:0] s_data_out,
    input  logic        s_ready,
    output logic        timeout_flag,
    input  logic        clr_timeout,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Counter value on the last wait cycle a grant may spend before abort.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        last_grant;
    logic [15:0] wait_cnt;

    logic        req0;
    logic        req1;
    logic        granted;
    logic        sel;
    logic [15:0] sel_address;
    logic [31:0] sel_data;
    logic        sel_wen;
    logic        sel_ren;
    logic        sel_req;
    logic        done_ok;
    logic        abort;
    logic        rdy;
    logic [31:0] dout;

    // View of the currently granted requester and this cycle's completion events.
    always_comb begin
        req0        = m0_wen | m0_ren;
        req1        = m1_wen | m1_ren;
        granted     = (state == GRANT0) || (state == GRANT1);
        sel         = (state == GRANT1);
        sel_address = sel ? m1_address : m0_address;
        sel_data    = sel ? m1_data_in : m0_data_in;
        sel_wen     = sel ? m1_wen : m0_wen;
        sel_ren     = sel ? m1_ren : m0_ren;
        sel_req     = sel_wen | sel_ren;
        // s_ready takes priority over the abort on the same cycle.
        done_ok     = granted && sel_req && s_ready;
        abort       = granted && sel_req && !s_ready && (wait_cnt == WAIT_LAST);
    end

    // Arbitration state, grant history, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            wait_cnt     <= 16'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (abort) begin
                timeout_flag <= 1'b1;
            end else if (clr_timeout) begin
                timeout_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    wait_cnt <= 16'd0;
                    if (req0 && (!req1 || last_grant)) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    // Completion, abort or a dropped request all end the grant.
                    if (!sel_req || s_ready || abort) begin
                        state      <= IDLE;
                        last_grant <= sel;
                        wait_cnt   <= 16'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    // Route the granted requester to the slave and the slave response back.
    always_comb begin
        s_address   = 16'd0;
        s_data_in   = 32'd0;
        s_wen       = 1'b0;
        s_ren       = 1'b0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_data_out = 32'd0;
        m1_data_out = 32'd0;
        rdy         = (done_ok | abort) & ~reset;
        dout        = abort ? 32'hFFFF_FFFF : s_data_out;
        if (granted) begin
            s_address = sel_address;
            s_data_in = sel_data;
            s_wen     = sel_wen;
            s_ren     = sel_ren & ~sel_wen;
            // A transfer caught by reset never reports completion.
            if (!reset) begin
                if (sel) begin
                    m1_ready    = rdy;
                    m1_data_out = dout;
                end else begin
                    m0_ready    = rdy;
                    m0_data_out = dout;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule
